// File: rtl/core_lsu.sv
// Load/store unit: turns EX-stage memory ops into single-outstanding req/gnt/rvalid
// bus transactions, steering store lanes and extending load data.
//
// state | meaning
// IDLE  | no access in flight; accepts or rejects a new EX memory op
// REQ   | request presented; bus outputs held until gnt
// WAIT  | granted; waiting for rvalid (read data or write ack)
module core_lsu #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_valid,
    input  logic [6:0]      i_opcode,
    input  logic [2:0]      i_funct3,
    input  logic [XLEN-1:0] i_addr,
    input  logic [XLEN-1:0] i_store_data,
    output logic            o_stall,
    output logic            o_load_valid,
    output logic [XLEN-1:0] o_load_data,
    output logic            o_lsu_err,
    output logic            o_dmem_req,
    output logic            o_dmem_we,
    output logic [3:0]      o_dmem_be,
    output logic [XLEN-1:0] o_dmem_addr,
    output logic [XLEN-1:0] o_dmem_wdata,
    input  logic            i_dmem_gnt,
    input  logic            i_dmem_rvalid,
    input  logic [XLEN-1:0] i_dmem_rdata
);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t          state;
    logic [2:0]      funct3_q;
    logic [1:0]      off_q;

    logic            is_load;
    logic            is_store;
    logic            mem_op;
    logic            f3_legal;
    logic            misaligned;
    logic            accept;
    logic            reject;
    logic [3:0]      be_next;
    logic [XLEN-1:0] wdata_next;
    logic [XLEN-1:0] rdata_shift;
    logic [XLEN-1:0] load_ext;

    always_comb begin
        is_load    = (i_opcode == OP_LOAD);
        is_store   = (i_opcode == OP_STORE);
        mem_op     = i_valid && (is_load || is_store);
        f3_legal   = 1'b0;
        if (is_load)
            f3_legal = (i_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        else if (is_store)
            f3_legal = (i_funct3 inside {3'b000, 3'b001, 3'b010});
        misaligned = 1'b0;
        case (i_funct3[1:0])
            2'b01:   misaligned = i_addr[0];
            2'b10:   misaligned = (i_addr[1:0] != 2'b00);
            default: misaligned = 1'b0;
        endcase
        accept  = (state == IDLE) && mem_op && f3_legal && !misaligned;
        reject  = (state == IDLE) && mem_op && !(f3_legal && !misaligned);
        o_stall = (state != IDLE) || accept;
    end

    // Sub-word stores replicate the data across every lane; be selects the live one.
    always_comb begin
        be_next    = 4'b1111;
        wdata_next = i_store_data;
        case (i_funct3[1:0])
            2'b00: begin
                be_next    = 4'b0001 << i_addr[1:0];
                wdata_next = {4{i_store_data[7:0]}};
            end
            2'b01: begin
                be_next    = 4'b0011 << i_addr[1:0];
                wdata_next = {2{i_store_data[15:0]}};
            end
            default: begin
                be_next    = 4'b1111;
                wdata_next = i_store_data;
            end
        endcase
    end

    always_comb begin
        rdata_shift = i_dmem_rdata >> {off_q, 3'b000};
        case (funct3_q)
            3'b000:  load_ext = {{24{rdata_shift[7]}}, rdata_shift[7:0]};
            3'b100:  load_ext = {24'd0, rdata_shift[7:0]};
            3'b001:  load_ext = {{16{rdata_shift[15]}}, rdata_shift[15:0]};
            3'b101:  load_ext = {16'd0, rdata_shift[15:0]};
            default: load_ext = i_dmem_rdata;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state        <= IDLE;
            funct3_q     <= 3'b000;
            off_q        <= 2'b00;
            o_dmem_req   <= 1'b0;
            o_dmem_we    <= 1'b0;
            o_dmem_be    <= 4'b0000;
            o_dmem_addr  <= '0;
            o_dmem_wdata <= '0;
            o_load_data  <= '0;
            o_load_valid <= 1'b0;
            o_lsu_err    <= 1'b0;
        end else begin
            o_load_valid <= 1'b0;
            o_lsu_err    <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        o_dmem_req   <= 1'b1;
                        o_dmem_we    <= is_store;
                        o_dmem_be    <= be_next;
                        o_dmem_addr  <= {i_addr[XLEN-1:2], 2'b00};
                        o_dmem_wdata <= wdata_next;
                        funct3_q     <= i_funct3;
                        off_q        <= i_addr[1:0];
                        state        <= REQ;
                    end else if (reject) begin
                        o_lsu_err <= 1'b1;
                    end
                end
                REQ: begin
                    if (i_dmem_gnt) begin
                        o_dmem_req <= 1'b0;
                        if (i_dmem_rvalid) begin
                            state <= IDLE;
                            if (!o_dmem_we) begin
                                o_load_data  <= load_ext;
                                o_load_valid <= 1'b1;
                            end
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (i_dmem_rvalid) begin
                        state <= IDLE;
                        if (!o_dmem_we) begin
                            o_load_data  <= load_ext;
                            o_load_valid <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_core_lsu.sv
// Directed bench for core_lsu: stimulus pushes expected bus/load/error events,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_core_lsu;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [1:0] EV_BUS  = 2'd0;
    localparam logic [1:0] EV_LOAD = 2'd1;
    localparam logic [1:0] EV_ERR  = 2'd2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid = 1'b0;
    logic [6:0]  opcode = '0;
    logic [2:0]  funct3 = '0;
    logic [31:0] addr = '0;
    logic [31:0] store_data = '0;
    logic        stall;
    logic        load_valid;
    logic [31:0] load_data;
    logic        lsu_err;
    logic        dmem_req;
    logic        dmem_we;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt = 1'b0;
    logic        dmem_rvalid = 1'b0;
    logic [31:0] dmem_rdata = '0;

    typedef struct {
        logic [1:0]  kind;
        logic [68:0] data;
    } ev_t;

    ev_t q[$];
    int  n_cmp = 0;
    int  n_fail = 0;
    int  stall_cnt = 0;
    int  req_cnt = 0;
    logic        prev_wait = 1'b0;
    logic [68:0] prev_bus = '0;

    core_lsu #(.XLEN(32)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_opcode(opcode),
        .i_funct3(funct3), .i_addr(addr), .i_store_data(store_data),
        .o_stall(stall), .o_load_valid(load_valid), .o_load_data(load_data),
        .o_lsu_err(lsu_err), .o_dmem_req(dmem_req), .o_dmem_we(dmem_we),
        .o_dmem_be(dmem_be), .o_dmem_addr(dmem_addr), .o_dmem_wdata(dmem_wdata),
        .i_dmem_gnt(dmem_gnt), .i_dmem_rvalid(dmem_rvalid), .i_dmem_rdata(dmem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [68:0] act, input logic [68:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic pop_event(input logic [1:0] kind, input logic [68:0] act);
        ev_t e;
        if (q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_event: got kind %0d data %h expected none", kind, act);
        end else begin
            e = q.pop_front();
            check("event_kind", {67'd0, kind}, {67'd0, e.kind});
            check("event_data", act, e.data);
        end
    endtask

    always @(negedge clk) begin
        logic [68:0] bus;
        bus = {dmem_we, dmem_be, dmem_addr, dmem_wdata};
        if (rst_n) begin
            if (prev_wait) begin
                check("req_held", {68'd0, dmem_req}, 69'd1);
                check("bus_stable", bus, prev_bus);
            end
            if (dmem_req && dmem_gnt) pop_event(EV_BUS, bus);
            if (load_valid)           pop_event(EV_LOAD, {37'd0, load_data});
            if (lsu_err)              pop_event(EV_ERR, 69'd0);
        end
        if (stall)    stall_cnt++;
        if (dmem_req) req_cnt++;
        prev_wait = rst_n && dmem_req && !dmem_gnt;
        prev_bus  = bus;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // gd: cycles of REQ before gnt; rvd: cycles after the gnt cycle until rvalid (0 = same cycle)
    task automatic do_access(input logic [6:0] op, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] sd,
                             input logic [31:0] rd, input int gd, input int rvd,
                             input logic is_err, input logic [68:0] exp_bus,
                             input logic [31:0] exp_load, input logic extra_rv);
        int s0;
        int r0;
        ev_t e;
        tick();
        valid = 1'b1; opcode = op; funct3 = f3; addr = a; store_data = sd;
        s0 = stall_cnt;
        r0 = req_cnt;
        if (is_err) begin
            e.kind = EV_ERR; e.data = '0; q.push_back(e);
        end else begin
            e.kind = EV_BUS; e.data = exp_bus; q.push_back(e);
            if (op == OP_LOAD) begin
                e.kind = EV_LOAD; e.data = {37'd0, exp_load}; q.push_back(e);
            end
        end
        tick();
        valid = 1'b0;
        if (!is_err) begin
            repeat (gd) tick();
            dmem_gnt = 1'b1; dmem_rvalid = (rvd == 0); dmem_rdata = rd;
            tick();
            dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
            if (rvd > 0) begin
                repeat (rvd - 1) tick();
                dmem_rvalid = 1'b1;
                tick();
                dmem_rvalid = 1'b0;
            end
        end
        repeat (2) tick();
        check("stall_cycles", 69'(stall_cnt - s0), is_err ? 69'd0 : 69'(2 + gd + rvd));
        check("req_cycles", 69'(req_cnt - r0), is_err ? 69'd0 : 69'(gd + 1));
        if (extra_rv) begin
            dmem_rvalid = 1'b1; dmem_rdata = 32'h5555_AAAA;
            tick();
            dmem_rvalid = 1'b0;
            repeat (2) tick();
            check("stall_after_stray_rvalid", 69'(stall_cnt - s0), 69'(2 + gd + rvd));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        ev_t e;
        repeat (3) tick();
        check("rst_outputs", {dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata}, 69'd0);
        check("rst_flags", {34'd0, load_data, load_valid, lsu_err, stall}, 69'd0);
        rst_n = 1'b1;
        tick();

        do_access(OP_STORE, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 0, 1, 1'b0,
                  {1'b1, 4'b1111, 32'h0000_0100, 32'hDEAD_BEEF}, 32'h0, 1'b0);
        do_access(OP_STORE, 3'b000, 32'h0000_0103, 32'h0000_00A5, 32'h0, 0, 1, 1'b0,
                  {1'b1, 4'b1000, 32'h0000_0100, 32'hA5A5_A5A5}, 32'h0, 1'b0);
        do_access(OP_STORE, 3'b001, 32'h0000_0102, 32'h1234_BEEF, 32'h0, 1, 0, 1'b0,
                  {1'b1, 4'b1100, 32'h0000_0100, 32'hBEEF_BEEF}, 32'h0, 1'b0);
        do_access(OP_LOAD, 3'b000, 32'h0000_0102, 32'h0, 32'h12F4_5678, 0, 1, 1'b0,
                  {1'b0, 4'b0100, 32'h0000_0100, 32'h0}, 32'hFFFF_FFF4, 1'b0);
        do_access(OP_LOAD, 3'b100, 32'h0000_0102, 32'h0, 32'h12F4_5678, 0, 0, 1'b0,
                  {1'b0, 4'b0100, 32'h0000_0100, 32'h0}, 32'h0000_00F4, 1'b0);
        do_access(OP_LOAD, 3'b101, 32'h0000_0102, 32'h0, 32'h12F4_5678, 0, 1, 1'b0,
                  {1'b0, 4'b1100, 32'h0000_0100, 32'h0}, 32'h0000_12F4, 1'b0);
        do_access(OP_LOAD, 3'b001, 32'h0000_0100, 32'h0, 32'h0000_8001, 0, 1, 1'b0,
                  {1'b0, 4'b0011, 32'h0000_0100, 32'h0}, 32'hFFFF_8001, 1'b0);
        do_access(OP_LOAD, 3'b001, 32'h0000_0101, 32'h0, 32'h0, 0, 0, 1'b1,
                  69'd0, 32'h0, 1'b0);
        do_access(OP_LOAD, 3'b011, 32'h0000_0100, 32'h0, 32'h0, 0, 0, 1'b1,
                  69'd0, 32'h0, 1'b0);
        do_access(OP_LOAD, 3'b010, 32'h0000_0204, 32'h0, 32'hCAFE_F00D, 3, 2, 1'b0,
                  {1'b0, 4'b1111, 32'h0000_0204, 32'h0}, 32'hCAFE_F00D, 1'b1);

        // Reset while waiting for rvalid: request dropped, late rvalid ignored
        tick();
        valid = 1'b1; opcode = OP_LOAD; funct3 = 3'b010; addr = 32'h0000_0300;
        e.kind = EV_BUS; e.data = {1'b0, 4'b1111, 32'h0000_0300, 32'h0}; q.push_back(e);
        tick();
        valid = 1'b0; dmem_gnt = 1'b1; dmem_rdata = 32'h7777_7777;
        tick();
        dmem_gnt = 1'b0;
        check("stall_in_wait", {68'd0, stall}, 69'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mid_rst_outputs", {dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata}, 69'd0);
        check("mid_rst_flags", {34'd0, load_data, load_valid, lsu_err, stall}, 69'd0);
        dmem_rvalid = 1'b1;
        tick();
        dmem_rvalid = 1'b0;
        repeat (3) tick();
        check("stall_after_stale", {68'd0, stall}, 69'd0);

        check("queue_drained", 69'(q.size()), 69'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/core_lsu.md
Name: core_lsu

Overview:
- Load/store unit between the EX stage and data memory; it consumes the EX-stage memory address (ALU result) and the forwarded rs2 store data.
- Issues word-aligned requests on a req/gnt/rvalid data-memory bus, with byte enables and store-data lane steering.
- Sign- or zero-extends load data and stalls the pipeline while an access is outstanding.
- Only one access is in flight at a time.

Parameters:
- XLEN, 32, data/address width; only 32 is supported.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst_n  input  1  synchronous active-low reset.
- i_valid  input  1  EX instruction valid this cycle.
- i_opcode  input  7  EX opcode; 0000011 = load, 0100011 = store.
- i_funct3  input  3  access size/sign.
- i_addr  input  XLEN  effective address (EX ALU result).
- i_store_data  input  XLEN  forwarded rs2 value.
- o_stall  output  1  hold the pipeline.
- o_load_valid  output  1  one-cycle pulse when o_load_data is valid.
- o_load_data  output  XLEN  extended load result.
- o_lsu_err  output  1  one-cycle pulse for a misaligned access or an illegal funct3.
- o_dmem_req  output  1  bus request.
- o_dmem_we  output  1  1 = write.
- o_dmem_be  output  4  byte enables.
- o_dmem_addr  output  XLEN  word address {addr[31:2], 2'b00}.
- o_dmem_wdata  output  XLEN  lane-steered store data.
- i_dmem_gnt  input  1  request accepted.
- i_dmem_rvalid  input  1  response; carries read data for loads, acts as ack for stores.
- i_dmem_rdata  input  XLEN  read data.

Behaviour:
- Reset (i_rst_n=0 at a clock edge):
  - State becomes IDLE.
  - All registered outputs (o_dmem_req, o_dmem_we, o_dmem_be, o_dmem_addr, o_dmem_wdata, o_load_data, o_load_valid, o_lsu_err) are cleared to 0.
  - Reset mid-access drops the request; any later rvalid is ignored.
- mem_op = i_valid and opcode is load or store.
- Legal funct3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
- Misaligned: halfword with addr[0]=1; word with addr[1:0]≠00.
- FSM states IDLE, REQ, WAIT:
  - IDLE, mem_op legal and aligned: register address/be/wdata/we/funct3/addr[1:0]; next state REQ.
  - IDLE, mem_op illegal or misaligned: o_lsu_err=1 next cycle for one cycle; no bus request; stay IDLE.
  - REQ: o_dmem_req=1; all bus outputs held stable until i_dmem_gnt.
    - gnt=1 and rvalid=0: go to WAIT, req drops.
    - gnt=1 and rvalid=1 in the same cycle: complete immediately.
  - WAIT: on rvalid, complete.
  - Completion:
    - Load: o_load_data registered from rdata; o_load_valid pulses 1 cycle.
    - Store: no load_valid.
    - Next state IDLE.
- o_stall (combinational) = (state≠IDLE) or (state==IDLE and mem_op legal and aligned).
  - Stall therefore asserts in the accept cycle and deasserts in the cycle after completion.
  - An erroring access does not stall.
- Byte enables and write data (k = addr[1:0]):
  - Byte: be = 0001<<k; wdata = {4{data[7:0]}}.
  - Half: be = 0011<<k; wdata = {2{data[15:0]}}.
  - Word: be = 1111; wdata = data.
- Load extraction:
  - Byte lane = rdata >> (8*k), low 8 bits; half lane = rdata >> (8*k), low 16 bits.
  - Sign-extend for LB/LH; zero-extend for LBU/LHU.
  - LW passes rdata unchanged.
- i_dmem_rvalid in IDLE or REQ-without-gnt is ignored.
- New EX inputs are ignored while state≠IDLE; EX holds them under stall.

Test Plan:
- SW at addr 0x100, data 0xDEADBEEF, gnt same cycle as req, rvalid one cycle later:
  - Bus shows we=1, be=1111, addr=0x100, wdata=0xDEADBEEF.
  - o_stall high for 3 cycles; no load_valid.
- SB at 0x103, data 0x000000A5:
  - be=1000, addr=0x100, wdata=0xA5A5A5A5.
- LB at 0x102 with rdata=0x12F45678:
  - load_data=0xFFFFFFF4, 1-cycle pulse.
  - LBU at the same address gives 0x000000F4.
  - LHU at 0x102 gives 0x000012F4.
- LH at 0x101, and separately funct3=011 load:
  - o_lsu_err pulses 1 cycle; o_dmem_req never asserts; o_stall stays 0.
- LW with gnt delayed 3 cycles and rvalid delayed 2 more:
  - req and addr stable for all 4 REQ cycles; stall continuous.
  - load_valid exactly once; an extra rvalid injected afterwards in IDLE has no effect.
- Reset asserted while in WAIT:
  - Next cycle state is IDLE, all outputs 0.
  - Stale rvalid afterwards does not produce load_valid.
